// File: rtl/wb_bram_sel.sv
// Wishbone slave around an inferred single-port RAM with byte-lane writes and registered ack/data.
// Define WB_BRAM_SEL_ERR_EN to reject out-of-range addresses with o_wbs_err instead of aliasing.
module wb_bram_sel #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int ADDR_LSB        = 0,
  parameter int WAIT_STATES     = 0,
  parameter     MEM_FILE        = "NOTHING",
  parameter int MEM_FILE_LENGTH = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wbs_we,
  input  logic                    i_wbs_stb,
  input  logic                    i_wbs_cyc,
  input  logic [DATA_WIDTH/8-1:0] i_wbs_sel,
  input  logic [31:0]             i_wbs_adr,
  input  logic [DATA_WIDTH-1:0]   i_wbs_dat,
  output logic [DATA_WIDTH-1:0]   o_wbs_dat,
  output logic                    o_wbs_ack,
  output logic                    o_wbs_err,
  output logic                    o_wbs_int
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic                    we_q;
  logic                    err_q;
  logic [SEL_W-1:0]        sel_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [DATA_WIDTH-1:0]   rd_q;
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
  logic                    req_err;
  logic                    access_ok;
  logic                    unused_adr;

`ifdef WB_BRAM_SEL_ERR_EN
  assign req_err = |(i_wbs_adr >> (ADDR_LSB + ADDR_WIDTH));
`else
  assign req_err = 1'b0;
`endif

  assign unused_adr = ^i_wbs_adr;
  assign o_wbs_int  = 1'b0;
  assign access_ok  = (state == S_ACCESS) && i_wbs_cyc;

  // RAM port: no reset so the array and its output register map onto block RAM.
  always_ff @(posedge clk) begin
    if (access_ok && !err_q) begin
      if (we_q) begin
        for (int k = 0; k < SEL_W; k++) begin
          if (sel_q[k]) mem[idx_q][8*k +: 8] <= dat_q[8*k +: 8];
        end
      end else begin
        rd_q <= mem[idx_q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      sel_q     <= '0;
      dat_q     <= '0;
      o_wbs_dat <= '0;
      o_wbs_ack <= 1'b0;
      o_wbs_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_wbs_stb && i_wbs_cyc) begin
            idx_q <= i_wbs_adr[ADDR_LSB +: ADDR_WIDTH];
            we_q  <= i_wbs_we;
            err_q <= req_err;
            sel_q <= i_wbs_sel;
            dat_q <= i_wbs_dat;
            state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          wait_cnt <= '0;
          state    <= i_wbs_cyc ? S_WAIT : S_IDLE;
        end
        // rd_q settles here; WAIT_STATES extra edges are counted before ack rises.
        S_WAIT: begin
          if (!i_wbs_cyc) begin
            state <= S_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            o_wbs_ack <= !err_q;
            o_wbs_err <= err_q;
            if (!we_q && !err_q) o_wbs_dat <= rd_q;
            state <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_ACK: begin
          if (!i_wbs_cyc || !i_wbs_stb) begin
            o_wbs_ack <= 1'b0;
            o_wbs_err <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bram_sel.sv
// Scoreboarded bench for wb_bram_sel: instance 0 has no wait states, instance 1 has three.
// Out-of-range expectations follow WB_BRAM_SEL_ERR_EN.
module tb_wb_bram_sel;

  logic        clk;
  logic        rst;
  logic        stb  [2];
  logic        cyc  [2];
  logic        we   [2];
  logic [3:0]  sel  [2];
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        ack  [2];
  logic        err  [2];
  logic        intr [2];

  typedef struct {
    logic        is_err;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [2][1024];
  logic [31:0] last_dat [2];
  int          n_checks = 0;
  int          n_pass   = 0;

  wb_bram_sel #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .i_wbs_we(we[0]), .i_wbs_stb(stb[0]), .i_wbs_cyc(cyc[0]),
    .i_wbs_sel(sel[0]), .i_wbs_adr(adr[0]), .i_wbs_dat(wdat[0]), .o_wbs_dat(rdat[0]),
    .o_wbs_ack(ack[0]), .o_wbs_err(err[0]), .o_wbs_int(intr[0])
  );

  wb_bram_sel #(.WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst), .i_wbs_we(we[1]), .i_wbs_stb(stb[1]), .i_wbs_cyc(cyc[1]),
    .i_wbs_sel(sel[1]), .i_wbs_adr(adr[1]), .i_wbs_dat(wdat[1]), .o_wbs_dat(rdat[1]),
    .o_wbs_ack(ack[1]), .o_wbs_err(err[1]), .o_wbs_int(intr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // One complete transfer: expectations are queued at drive time and popped when ack/err appears.
  task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                               input logic [31:0] data, input logic [3:0] s, input int hold);
    exp_t e;
    logic exp_err;
    logic got;
    int   lat;
    int   idx;
    idx = int'(a[9:0]);
`ifdef WB_BRAM_SEL_ERR_EN
    exp_err = (a[31:10] != 22'd0);
`else
    exp_err = 1'b0;
`endif
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = data; sel[d] = s;
    e.is_err = exp_err;
    e.dat    = (w || exp_err) ? last_dat[d] : model[d][idx];
    sb.push_back(e);
    if (w && !exp_err) begin
      for (int k = 0; k < 4; k++) begin
        if (s[k]) model[d][idx][8*k +: 8] = data[8*k +: 8];
      end
    end
    @(posedge clk);
    #1;
    adr[d]  = a ^ 32'h1;
    wdat[d] = ~data;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (ack[d] || err[d]) got = 1'b1;
    end
    e = sb.pop_front();
    if (got) begin
      checkOutput("latency", lat, (d == 0) ? 32'd2 : 32'd5);
      checkOutput("ack", {31'd0, ack[d]}, {31'd0, !e.is_err});
      checkOutput("err", {31'd0, err[d]}, {31'd0, e.is_err});
      checkOutput("rdata", rdat[d], e.dat);
      if (!w && !e.is_err) last_dat[d] = e.dat;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        checkOutput("ack_hold", {31'd0, ack[d] | err[d]}, 32'd1);
        checkOutput("rdata_hold", rdat[d], e.dat);
      end
    end else begin
      checkOutput("timeout", 32'd0, 32'd1);
    end
    @(negedge clk);
    stb[d] = 1'b0; cyc[d] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ack_drop", {31'd0, ack[d] | err[d]}, 32'd0);
  endtask

  // Request sampled, then cyc dropped before the ACCESS edge: no ack and no RAM update.
  task automatic abortWrite(input int d, input logic [31:0] a, input logic [31:0] data);
    logic seen;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; adr[d] = a; wdat[d] = data; sel[d] = 4'hF;
    @(negedge clk);
    cyc[d] = 1'b0; stb[d] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      seen = seen | ack[d] | err[d];
    end
    checkOutput("abort_no_ack", {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] dv;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      stb[d] = 1'b1; cyc[d] = 1'b1; we[d] = 1'b0; sel[d] = 4'hF;
      adr[d] = 32'h5; wdat[d] = 32'h0; last_dat[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset_ack", {31'd0, ack[d]}, 32'd0);
      checkOutput("reset_err", {31'd0, err[d]}, 32'd0);
      checkOutput("reset_dat", rdat[d], 32'd0);
      checkOutput("reset_int", {31'd0, intr[d]}, 32'd0);
    end
    @(negedge clk);
    stb[0] = 1'b0; cyc[0] = 1'b0; stb[1] = 1'b0; cyc[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Basic word write/read, then byte lanes and an empty-sel write.
    applyStimulus(0, 1'b1, 32'h005, 32'hDEADBEEF, 4'hF, 0);
    applyStimulus(0, 1'b0, 32'h005, 32'h0, 4'hF, 0);
    applyStimulus(0, 1'b1, 32'h010, 32'h11223344, 4'hF, 0);
    applyStimulus(0, 1'b1, 32'h010, 32'hAABBCCDD, 4'b0101, 0);
    applyStimulus(0, 1'b0, 32'h010, 32'h0, 4'b0000, 0);
    applyStimulus(0, 1'b1, 32'h005, 32'h0, 4'b0000, 0);
    applyStimulus(0, 1'b0, 32'h005, 32'h0, 4'hF, 1);

    // Abort leaves the old word in place.
    applyStimulus(0, 1'b1, 32'h020, 32'h12345678, 4'hF, 0);
    abortWrite(0, 32'h020, 32'h0);
    applyStimulus(0, 1'b0, 32'h020, 32'h0, 4'hF, 0);

    // Upper address bits: error response or aliasing onto index 0.
    applyStimulus(0, 1'b1, 32'h000, 32'hCAFEF00D, 4'hF, 0);
    applyStimulus(0, 1'b0, 32'h400, 32'h0, 4'hF, 2);
    applyStimulus(0, 1'b1, 32'h400, 32'h55AA55AA, 4'hF, 0);
    applyStimulus(0, 1'b0, 32'h000, 32'h0, 4'hF, 0);

    // Wait-state instance, including a long stb hold on the read.
    applyStimulus(1, 1'b1, 32'h003, 32'hA5A5F00F, 4'hF, 0);
    applyStimulus(1, 1'b0, 32'h003, 32'h0, 4'hF, 4);
    applyStimulus(1, 1'b1, 32'h003, 32'h00990000, 4'b0100, 0);
    applyStimulus(1, 1'b0, 32'h003, 32'h0, 4'hF, 0);

    // Random partial writes and reads over a small, fully initialised window.
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 32'h40 + i, $urandom, 4'hF, 0);
    for (int i = 0; i < 24; i++) begin
      a  = 32'h40 + $urandom_range(0, 7);
      dv = $urandom;
      applyStimulus(0, 1'($urandom_range(0, 1)), a, dv, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
